muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between a pipeline issue stage and muldiv_unit.
//   start, funct3, rs1, rs2, rd   -- request, driven by the master
//   busy, done, we, waddr, wdata  -- status and register-file write port, driven by the slave
interface muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport master (
        output start, funct3, rs1, rs2, rd,
        input  busy, done, we, waddr, wdata
    );

    modport slave (
        input  start, funct3, rs1, rs2, rd,
        output busy, done, we, waddr, wdata
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit.
//   clk  -- clock
//   rst  -- asynchronous, active-high reset
//   bus  -- muldiv_if.slave: start/funct3/rs1/rs2/rd request in,
//           busy/done and register-file write port (we/waddr/wdata) out
// Multiplies take 2 cycles, divides 33 cycles (32-step restoring divider);
// divide-by-zero and signed overflow finish in 1 cycle.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t      state_q, state_d;

    logic [1:0]  op_q;       // funct3[1:0]; funct3[2] only steers the next state
    logic [31:0] a_q, b_q;   // raw operands, for sign decisions
    logic [4:0]  rd_q;
    logic [4:0]  cnt_q;
    logic [31:0] quot_q;     // holds dividend magnitude, shifts into quotient
    logic [31:0] rem_q;
    logic [31:0] dvs_q;      // divisor magnitude
    logic [31:0] result_q;

    // Request decode, only meaningful in IDLE.
    logic        accept;
    logic        in_signed;
    logic        in_dbz;
    logic        in_ovf;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;

    assign accept    = (state_q == IDLE) && bus.start;
    assign in_signed = ~bus.funct3[0];
    assign in_dbz    = (bus.rs2 == '0);
    assign in_ovf    = in_signed && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == '1);
    assign in_a_mag  = (in_signed && bus.rs1[31]) ? (32'd0 - bus.rs1) : bus.rs1;
    assign in_b_mag  = (in_signed && bus.rs2[31]) ? (32'd0 - bus.rs2) : bus.rs2;

    // Multiplier: sign-extend each operand as its op requires, keep 64 bits.
    logic        a_sx, b_sx;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] mul_res;

    assign a_sx    = a_q[31] && ((op_q == 2'b01) || (op_q == 2'b10));
    assign b_sx    = b_q[31] && (op_q == 2'b01);
    assign a_ext   = {{32{a_sx}}, a_q};
    assign b_ext   = {{32{b_sx}}, b_q};
    assign prod    = a_ext * b_ext;
    assign mul_res = (op_q == 2'b00) ? prod[31:0] : prod[63:32];

    // One restoring step: a negative trial difference (bit 32) restores.
    logic [32:0] shifted, diff;
    logic [31:0] q_nxt, r_nxt, q_fix, r_fix, div_res;
    logic        neg_q, neg_r;

    assign shifted = {rem_q, quot_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign q_nxt   = {quot_q[30:0], ~diff[32]};
    assign r_nxt   = diff[32] ? shifted[31:0] : diff[31:0];
    assign neg_q   = ~op_q[0] && (a_q[31] ^ b_q[31]);
    assign neg_r   = ~op_q[0] && a_q[31];
    assign q_fix   = neg_q ? (32'd0 - q_nxt) : q_nxt;
    assign r_fix   = neg_r ? (32'd0 - r_nxt) : r_nxt;
    assign div_res = op_q[1] ? r_fix : q_fix;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.funct3[2])        state_d = MUL;
                    else if (in_dbz || in_ovf) state_d = FIN;
                    else                       state_d = DIV;
                end
            end
            MUL:     state_d = FIN;
            DIV:     if (cnt_q == 5'd0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register and result/rd registers only.
    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.done  = (state_q == FIN);
        bus.we    = (state_q == FIN) && (rd_q != 5'd0);
        bus.waddr = (state_q == FIN) ? rd_q : '0;
        bus.wdata = (state_q == FIN) ? result_q : '0;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.funct3[1:0];
                        a_q    <= bus.rs1;
                        b_q    <= bus.rs2;
                        rd_q   <= bus.rd;
                        cnt_q  <= 5'd31;
                        quot_q <= in_a_mag;
                        rem_q  <= '0;
                        dvs_q  <= in_b_mag;
                        // Special divide cases resolve here and skip DIV.
                        if (in_dbz)
                            result_q <= bus.funct3[1] ? bus.rs1 : '1;
                        else if (in_ovf)
                            result_q <= bus.funct3[1] ? '0 : 32'h8000_0000;
                        else
                            result_q <= '0;
                    end
                end
                MUL: begin
                    result_q <= mul_res;
                end
                DIV: begin
                    quot_q <= q_nxt;
                    rem_q  <= r_nxt;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) result_q <= div_res;
                end
                default: ;
            endcase
        end
    end

endmodule
